// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path and the blocks around it:
//   - uart_rx_state_t      : receiver FSM state encoding
//   - DEFAULT_CLKS_PER_BIT : bit period in clocks (100 MHz / 115200 baud)
//   - CMD_RECV_DATA/CMD_SEND_DATA : command bytes understood by the command
//     state machine and the transmitter
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic [7:0] CMD_RECV_DATA = 8'd69;
  localparam logic [7:0] CMD_SEND_DATA = 8'd42;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input. Both flops load
// RESET_VAL on reset so an idle-high line does not look like an edge.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-high
//   i_d   - asynchronous input
//   o_q   - synchronised output (2 cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8N1 serial receiver feeding the command state machine. Start bits are
// validated at mid-bit, data bits are sampled LSB first at mid-bit, and only
// frames with a high stop bit produce a byte.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high
//   rxd       - raw serial line (asynchronous, idle high)
//   recv      - one-cycle strobe, a new byte is on uart_rx
//   uart_rx   - last correctly framed byte, held until the next one
//   frame_err - one-cycle strobe, stop bit was sampled low
//   busy      - receiver is anywhere but IDLE
// ---------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       recv,
  output logic [7:0] uart_rx,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic w_rxS;

  uart_rx_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_uartRx;
  logic             r_recv;
  logic             r_frameErr;

  uart_rx_state_t   w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [2:0]       w_idxNext;
  logic [7:0]       w_shiftNext;
  logic [7:0]       w_uartRxNext;
  logic             w_recvNext;
  logic             w_frameErrNext;

  // Idle-high line: synchroniser resets to 1 so reset release is not a start.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rxSync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rxd),
    .o_q   (w_rxS)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_uartRx   <= '0;
      r_recv     <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_idx      <= w_idxNext;
      r_shift    <= w_shiftNext;
      r_uartRx   <= w_uartRxNext;
      r_recv     <= w_recvNext;
      r_frameErr <= w_frameErrNext;
    end
  end

  // The half-bit wait in START puts every later sample (one full bit period
  // apart) near the middle of its bit. Leaving STOP at the stop-bit sample
  // gives half a bit of slack before the next start edge can arrive.
  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_idxNext      = r_idx;
    w_shiftNext    = r_shift;
    w_uartRxNext   = r_uartRx;
    w_recvNext     = 1'b0;
    w_frameErrNext = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rxS) begin
          w_stateNext = START;
          w_cntNext   = '0;
        end
      end

      START: begin
        if (r_cnt == CNT_HALF_LAST) begin
          w_cntNext = '0;
          if (!w_rxS) begin
            w_stateNext = DATA;
            w_idxNext   = '0;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      DATA: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cntNext          = '0;
          w_shiftNext[r_idx] = w_rxS;
          if (r_idx == 3'd7) begin
            w_stateNext = STOP;
          end else begin
            w_idxNext = r_idx + 3'd1;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      STOP: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cntNext = '0;
          if (w_rxS) begin
            w_uartRxNext = r_shift;
            w_recvNext   = 1'b1;
            w_stateNext  = IDLE;
          end else begin
            w_frameErrNext = 1'b1;
            w_stateNext    = BREAK;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end

      // A low stop bit may be a line break; wait for the line to recover
      // before hunting for a start bit again.
      BREAK: begin
        if (w_rxS) begin
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign recv      = r_recv;
  assign uart_rx   = r_uartRx;
  assign frame_err = r_frameErr;
  assign busy      = (r_state != IDLE);

`ifndef SYNTHESIS
  string stateName;
  always_comb begin
    stateName = r_state.name();
  end
`endif

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Two receivers: a fast one (16 clocks/bit) for directed and random frames,
// and a full-rate one (868 clocks/bit) for baud-tolerance frames.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB      = 16;
  localparam int HALF     = CPB / 2;
  localparam int CPB_FULL = 868;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rxdA  = 1'b1;
  logic       rxdB  = 1'b1;

  logic       recvA, feA, busyA;
  logic [7:0] uartRxA;
  logic       recvB, feB, busyB;
  logic [7:0] uartRxB;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: bytes that must come out, in order, plus error counts.
  logic [7:0] expA[$];
  logic [7:0] expB[$];
  int         expFeA   = 0;
  logic [7:0] lastByteA = 8'h00;

  // Observations collected from the outputs.
  logic [7:0] gotA[$];
  logic [7:0] gotB[$];
  int         feCountA = 0;
  int         feCountB = 0;
  int         strobeViol = 0;
  logic       prevStrobeA = 1'b0;
  logic       prevStrobeB = 1'b0;
  time        lastRecvTimeA = 0;
  logic       busyAtRecvA = 1'b0;
  time        tStart = 0;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dutA (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxdA),
    .recv      (recvA),
    .uart_rx   (uartRxA),
    .frame_err (feA),
    .busy      (busyA)
  );

  uart_receiver #(.CLKS_PER_BIT(CPB_FULL)) dutB (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxdB),
    .recv      (recvB),
    .uart_rx   (uartRxB),
    .frame_err (feB),
    .busy      (busyB)
  );

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (recvA) begin
      gotA.push_back(uartRxA);
      lastRecvTimeA = $time;
      busyAtRecvA   = busyA;
    end
    if (feA) feCountA++;
    if (recvA && feA) strobeViol++;
    if ((recvA || feA) && prevStrobeA) strobeViol++;
    prevStrobeA = recvA || feA;

    if (recvB) gotB.push_back(uartRxB);
    if (feB) feCountB++;
    if (recvB && feB) strobeViol++;
    if ((recvB || feB) && prevStrobeB) strobeViol++;
    prevStrobeB = recvB || feB;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives happen 1 ns after a rising edge to stay clear of the sampling flop.
  task automatic waitCycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic driveLine(input bit toFull, input logic v);
    if (toFull) rxdB = v;
    else        rxdA = v;
  endtask

  // One 8N1 frame: start, 8 data bits LSB first, stop (optionally low).
  task automatic applyStimulus(input bit toFull, input logic [7:0] data,
                               input int period, input bit stopGood);
    logic [9:0] bits;
    bits   = {stopGood, data, 1'b0};
    tStart = $time;
    for (int i = 0; i < 10; i++) begin
      driveLine(toFull, bits[i]);
      waitCycles(period);
    end
  endtask

  task automatic checkScoreboardA(input string tag);
    int n;
    checkOutput({tag, "_recvCount"}, 32'(gotA.size()), 32'(expA.size()));
    n = (gotA.size() < expA.size()) ? gotA.size() : expA.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_byte"}, 32'(gotA[i]), 32'(expA[i]));
    end
    gotA.delete();
    expA.delete();
    checkOutput({tag, "_frameErrCount"}, 32'(feCountA), 32'(expFeA));
    checkOutput({tag, "_uartRx"}, 32'(uartRxA), 32'(lastByteA));
    checkOutput({tag, "_strobeRules"}, 32'(strobeViol), 32'd0);
  endtask

  initial begin
    logic [7:0] data;
    bit         good;

    // Reset state.
    waitCycles(3);
    checkOutput("reset_recv",     32'(recvA),   32'd0);
    checkOutput("reset_frameErr", 32'(feA),     32'd0);
    checkOutput("reset_busy",     32'(busyA),   32'd0);
    checkOutput("reset_uartRx",   32'(uartRxA), 32'h00);
    reset = 1'b0;
    waitCycles(4);

    // Single byte 0x45: value, timing from start edge, busy after stop sample.
    applyStimulus(0, 8'h45, CPB, 1);
    expA.push_back(8'h45);
    lastByteA = 8'h45;
    waitCycles(2 * CPB);
    checkOutput("byte45_latency", 32'((lastRecvTimeA - tStart) / 10), 32'(2 + 1 + HALF + 9 * CPB));
    checkOutput("byte45_busyAtRecv", 32'(busyAtRecvA), 32'd0);
    checkScoreboardA("byte45");

    // Back-to-back 0x2A then 0x6F.
    applyStimulus(0, 8'h2A, CPB, 1);
    applyStimulus(0, 8'h6F, CPB, 1);
    expA.push_back(8'h2A);
    expA.push_back(8'h6F);
    lastByteA = 8'h6F;
    waitCycles(2 * CPB);
    checkScoreboardA("backToBack");

    // Short glitch from idle is rejected.
    rxdA = 1'b0;
    waitCycles(4);
    rxdA = 1'b1;
    waitCycles(3 * CPB);
    checkOutput("glitch_busy", 32'(busyA), 32'd0);
    checkScoreboardA("glitch");

    // 0x55 with low stop bit, line held low, then a good 0xA5.
    applyStimulus(0, 8'h55, CPB, 0);
    expFeA++;
    waitCycles(20);
    checkOutput("break_busy", 32'(busyA), 32'd1);
    checkOutput("break_frameErrCount", 32'(feCountA), 32'(expFeA));
    checkOutput("break_uartRxHeld", 32'(uartRxA), 32'(lastByteA));
    waitCycles(20);
    rxdA = 1'b1;
    waitCycles(CPB);
    applyStimulus(0, 8'hA5, CPB, 1);
    expA.push_back(8'hA5);
    lastByteA = 8'hA5;
    waitCycles(2 * CPB);
    checkScoreboardA("frameErr");

    // Reset during data bit 3 of 0xFF, then 0x01.
    rxdA = 1'b0;
    waitCycles(CPB);
    rxdA = 1'b1;
    waitCycles(3 * CPB + HALF);
    checkOutput("midFrame_busy", 32'(busyA), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("midReset_recv",     32'(recvA),   32'd0);
    checkOutput("midReset_frameErr", 32'(feA),     32'd0);
    checkOutput("midReset_busy",     32'(busyA),   32'd0);
    checkOutput("midReset_uartRx",   32'(uartRxA), 32'h00);
    waitCycles(3);
    reset = 1'b0;
    lastByteA = 8'h00;
    waitCycles(2 * CPB);
    checkOutput("postReset_recvCount", 32'(gotA.size()), 32'd0);
    applyStimulus(0, 8'h01, CPB, 1);
    expA.push_back(8'h01);
    lastByteA = 8'h01;
    waitCycles(2 * CPB);
    checkScoreboardA("afterReset");

    // Random frames: random data, gaps (including none), occasional low stop.
    for (int f = 0; f < 24; f++) begin
      data = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      applyStimulus(0, data, CPB, good);
      if (good) begin
        expA.push_back(data);
        lastByteA = data;
        waitCycles($urandom_range(0, 20));
      end else begin
        expFeA++;
        waitCycles($urandom_range(5, 30));
        rxdA = 1'b1;
        waitCycles(CPB + $urandom_range(0, 10));
      end
    end
    waitCycles(2 * CPB);
    checkScoreboardA("random");

    // Full-rate receiver with the sender's bit period 2% slow and 2% fast.
    applyStimulus(1, 8'h45, 885, 1);
    expB.push_back(8'h45);
    waitCycles(2 * CPB_FULL);
    applyStimulus(1, 8'h45, 851, 1);
    expB.push_back(8'h45);
    waitCycles(2 * CPB_FULL);
    checkOutput("baud_recvCount", 32'(gotB.size()), 32'(expB.size()));
    for (int i = 0; i < gotB.size() && i < expB.size(); i++) begin
      checkOutput("baud_byte", 32'(gotB[i]), 32'(expB[i]));
    end
    checkOutput("baud_frameErrCount", 32'(feCountB), 32'd0);
    checkOutput("baud_busy", 32'(busyB), 32'd0);
    checkOutput("final_strobeRules", 32'(strobeViol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
